// File: rtl/width_gearbox.sv
// width_gearbox: packs IN_W-bit input words into OUT_W-bit output words through
// a shift accumulator. Bits are kept in stream order with the earliest bit at
// acc[0]. A flush drains residual bits and marks the final, zero-padded word.
module width_gearbox #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 10,
    parameter int ACC_W     = 32,
    parameter int MSB_FIRST = 0,
    localparam int CNT_W    = $clog2(ACC_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] fill_bits
);

    localparam logic [CNT_W-1:0] IN_C   = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_C  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] IN_LIM = CNT_W'(ACC_W - IN_W);

    // ST_DRAIN is the flush-pending phase: input blocked until the last word pops
    typedef enum logic {ST_FILL, ST_DRAIN} state_t;

    state_t             state, state_next;
    logic [ACC_W-1:0]   acc, acc_next, in_ext;
    logic [CNT_W-1:0]   cnt, cnt_next, popped;
    logic [IN_W-1:0]    in_bits;
    logic [OUT_W-1:0]   word_lsb;
    logic               flush_pend, push, pop;

    // Normalise both sides to earliest-bit-at-LSB; bits at or above cnt are
    // masked so a partial word is always zero-padded
    generate
        for (genvar i = 0; i < IN_W; i++) begin : g_in
            assign in_bits[i] = (MSB_FIRST != 0) ? in_data[IN_W-1-i] : in_data[i];
        end
        for (genvar j = 0; j < OUT_W; j++) begin : g_out
            assign word_lsb[j] = acc[j] & (cnt > CNT_W'(j));
            assign out_data[j] = (MSB_FIRST != 0) ? word_lsb[OUT_W-1-j] : word_lsb[j];
        end
    endgenerate

    assign flush_pend = (state == ST_DRAIN);
    assign in_ready   = !flush_pend && (cnt <= IN_LIM);
    assign out_valid  = (cnt >= OUT_C) || (flush_pend && (cnt != '0));
    assign out_last   = out_valid && flush_pend && (cnt <= OUT_C);
    assign fill_bits  = cnt;
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign in_ext     = ACC_W'(in_bits);

    // Datapath: consume the popped bits, then append the pushed word above
    // whatever remains; bits above cnt are always zero so a plain OR suffices
    always_comb begin
        popped = '0;
        if (pop)
            popped = (cnt < OUT_C) ? cnt : OUT_C;
        cnt_next = cnt - popped + (push ? IN_C : '0);
        acc_next = acc >> popped;
        if (push)
            acc_next = acc_next | (in_ext << (cnt - popped));
    end

    // Flush control: enter drain only if bits remain after this cycle, so an
    // empty drain (which could never emit its last word) cannot occur
    always_comb begin
        state_next = state;
        case (state)
            ST_FILL:  if (flush && (cnt_next != '0)) state_next = ST_DRAIN;
            ST_DRAIN: if (pop && out_last)           state_next = ST_FILL;
            default:                                 state_next = ST_FILL;
        endcase
    end

    // State registers; reset discards all residual bits and any pending flush
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_FILL;
        end else begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            state <= state_next;
        end
    end

endmodule

// File: tb/tb_width_gearbox.sv
// tb_width_gearbox: directed scenarios plus a randomized run checked against a
// bit-queue model of the packed stream.
module tb_width_gearbox;

    localparam int IN_W  = 16;
    localparam int OUT_W = 10;
    localparam int ACC_W = 32;
    localparam int CNT_W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance (16 -> 10, LSB first)
    logic [IN_W-1:0]  m_in_data = '0;
    logic             m_in_valid = 1'b0, m_in_ready, m_flush = 1'b0;
    logic [OUT_W-1:0] m_out_data;
    logic             m_out_valid, m_out_ready = 1'b1, m_out_last;
    logic [CNT_W-1:0] m_fill;

    // 16 -> 8 instances, a: MSB first, b: LSB first
    logic [15:0] s_in_data = '0;
    logic        s_in_valid = 1'b0, s_flush = 1'b0, s_out_ready = 1'b1;
    logic        a_in_ready, a_out_valid, a_out_last, b_in_ready, b_out_valid, b_out_last;
    logic [7:0]  a_out_data, b_out_data;
    logic [5:0]  a_fill, b_fill;

    int total = 0;
    int bad   = 0;

    logic [OUT_W-1:0] got_d[$];
    bit               got_l[$];
    logic [7:0]       got_a[$], got_b[$];

    width_gearbox #(.IN_W(IN_W), .OUT_W(OUT_W), .ACC_W(ACC_W), .MSB_FIRST(0)) u_main (
        .clk(clk), .rst(rst), .in_data(m_in_data), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .flush(m_flush), .out_data(m_out_data), .out_valid(m_out_valid), .out_ready(m_out_ready),
        .out_last(m_out_last), .fill_bits(m_fill));

    width_gearbox #(.IN_W(16), .OUT_W(8), .ACC_W(32), .MSB_FIRST(1)) u_msb (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(a_in_ready),
        .flush(s_flush), .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(s_out_ready),
        .out_last(a_out_last), .fill_bits(a_fill));

    width_gearbox #(.IN_W(16), .OUT_W(8), .ACC_W(32), .MSB_FIRST(0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(s_in_data), .in_valid(s_in_valid), .in_ready(b_in_ready),
        .flush(s_flush), .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(s_out_ready),
        .out_last(b_out_last), .fill_bits(b_fill));

    // One clock: record words that will pop at the coming edge, then advance
    // to the next falling edge (state is stable there, inputs are driven there)
    task automatic tick();
        if (!rst && m_out_valid && m_out_ready) begin
            got_d.push_back(m_out_data);
            got_l.push_back(m_out_last);
        end
        if (!rst && a_out_valid && s_out_ready) got_a.push_back(a_out_data);
        if (!rst && b_out_valid && s_out_ready) got_b.push_back(b_out_data);
        @(negedge clk);
    endtask

    task automatic clear_got();
        got_d.delete(); got_l.delete(); got_a.delete(); got_b.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%0b exp=0", m_out_valid); end
        total++; if (m_out_last !== 1'b0) begin bad++; $display("FAIL reset out_last got=%0b exp=0", m_out_last); end
        total++; if (m_out_data !== 10'h000) begin bad++; $display("FAIL reset out_data got=%h exp=000", m_out_data); end
        total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready got=%0b exp=1", m_in_ready); end
        total++; if (m_fill !== 6'd0) begin bad++; $display("FAIL reset fill_bits got=%0d exp=0", m_fill); end
    endtask

    task automatic test_basic_flush();
        logic [9:0] exp_w[3] = '{10'h3FF, 10'h03F, 10'h000};
        clear_got();
        m_in_valid = 1'b1; m_in_data = 16'hFFFF; tick();
        m_in_data = 16'h0000; tick();
        m_in_valid = 1'b0;
        repeat (4) tick();
        total++;
        if (got_d.size() != 3) begin bad++; $display("FAIL basic word_count got=%0d exp=3", got_d.size()); end
        else for (int k = 0; k < 3; k++) begin
            total++;
            if (got_d[k] !== exp_w[k]) begin bad++; $display("FAIL basic word%0d got=%h exp=%h", k, got_d[k], exp_w[k]); end
        end
        total++; if (m_fill !== 6'd2) begin bad++; $display("FAIL basic residual fill got=%0d exp=2", m_fill); end
        total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL basic partial out_valid got=%0b exp=0", m_out_valid); end
        clear_got();
        m_flush = 1'b1; tick();
        m_flush = 1'b0;
        total++; if (m_out_valid !== 1'b1 || m_out_last !== 1'b1) begin bad++; $display("FAIL flush last_word valid/last got=%0b/%0b exp=1/1", m_out_valid, m_out_last); end
        total++; if (m_in_ready !== 1'b0) begin bad++; $display("FAIL flush in_ready_blocked got=%0b exp=0", m_in_ready); end
        tick(); tick();
        total++;
        if (got_d.size() != 1) begin bad++; $display("FAIL flush word_count got=%0d exp=1", got_d.size()); end
        else if (got_d[0] !== 10'h000 || got_l[0] !== 1'b1) begin bad++; $display("FAIL flush word got=%h/last=%0b exp=000/last=1", got_d[0], got_l[0]); end
        total++; if (m_fill !== 6'd0 || m_in_ready !== 1'b1) begin bad++; $display("FAIL flush after fill/in_ready got=%0d/%0b exp=0/1", m_fill, m_in_ready); end
    endtask

    task automatic test_stream();
        logic [15:0] w[5] = '{16'hA5C3, 16'h1E0F, 16'h7777, 16'h0F0F, 16'hDEAD};
        logic [79:0] cat, exp_cat;
        int i = 0, cyc = 0;
        bit accepted, any_last;
        clear_got();
        while (i < 5 && cyc < 60) begin
            m_in_valid = 1'b1; m_in_data = w[i];
            accepted = m_in_ready;
            tick();
            if (accepted) i++;
            cyc++;
        end
        m_in_valid = 1'b0;
        total++; if (i != 5) begin bad++; $display("FAIL stream accept_timeout accepted=%0d exp=5", i); end
        repeat (8) tick();
        total++; if (got_d.size() != 8) begin bad++; $display("FAIL stream word_count got=%0d exp=8", got_d.size()); end
        else begin
            cat = '0; any_last = 1'b0;
            for (int k = 0; k < 8; k++) begin cat[k*10 +: 10] = got_d[k]; any_last |= got_l[k]; end
            exp_cat = {w[4], w[3], w[2], w[1], w[0]};
            total++; if (cat !== exp_cat) begin bad++; $display("FAIL stream concat got=%h exp=%h", cat, exp_cat); end
            total++; if (any_last !== 1'b0) begin bad++; $display("FAIL stream out_last got=1 exp=0"); end
        end
        total++; if (m_fill !== 6'd0) begin bad++; $display("FAIL stream end fill got=%0d exp=0", m_fill); end
    endtask

    task automatic test_back_pressure();
        logic [15:0] w0 = 16'($urandom), w1 = 16'($urandom);
        logic [31:0] bits;
        int n = 0;
        bit accepted;
        clear_got();
        m_out_ready = 1'b0;
        for (int c = 0; c < 8 && m_in_ready; c++) begin
            m_in_valid = 1'b1;
            m_in_data = (n == 0) ? w0 : (n == 1) ? w1 : 16'($urandom);
            accepted = m_in_ready;
            tick();
            if (accepted) n++;
        end
        m_in_valid = 1'b0;
        total++; if (n != 2) begin bad++; $display("FAIL bp accepted got=%0d exp=2", n); end
        total++; if (m_fill !== 6'd32 || m_in_ready !== 1'b0) begin bad++; $display("FAIL bp full fill/in_ready got=%0d/%0b exp=32/0", m_fill, m_in_ready); end
        repeat (3) tick();
        total++; if (m_out_valid !== 1'b1 || m_out_data !== w0[9:0]) begin bad++; $display("FAIL bp hold valid/data got=%0b/%h exp=1/%h", m_out_valid, m_out_data, w0[9:0]); end
        m_out_ready = 1'b1;
        repeat (4) tick();
        bits = {w1, w0};
        total++;
        if (got_d.size() != 3) begin bad++; $display("FAIL bp word_count got=%0d exp=3", got_d.size()); end
        else if (got_d[0] !== bits[9:0] || got_d[1] !== bits[19:10] || got_d[2] !== bits[29:20]) begin
            bad++; $display("FAIL bp words got=%h,%h,%h exp=%h,%h,%h", got_d[0], got_d[1], got_d[2], bits[9:0], bits[19:10], bits[29:20]);
        end
        total++; if (m_fill !== 6'd2 || m_in_ready !== 1'b1) begin bad++; $display("FAIL bp after fill/in_ready got=%0d/%0b exp=2/1", m_fill, m_in_ready); end
        m_flush = 1'b1; tick(); m_flush = 1'b0; tick();
        clear_got();
    endtask

    task automatic test_bit_order();
        clear_got();
        s_in_valid = 1'b1; s_in_data = 16'hABCD; tick();
        s_in_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (got_a.size() != 2 || got_a[0] !== 8'hAB || got_a[1] !== 8'hCD) begin
            bad++; $display("FAIL msb_first words count=%0d first=%h exp=2 words AB,CD", got_a.size(), (got_a.size() > 0) ? got_a[0] : 8'hxx);
        end
        total++;
        if (got_b.size() != 2 || got_b[0] !== 8'hCD || got_b[1] !== 8'hAB) begin
            bad++; $display("FAIL lsb_first words count=%0d first=%h exp=2 words CD,AB", got_b.size(), (got_b.size() > 0) ? got_b[0] : 8'hxx);
        end
    endtask

    task automatic test_reset_mid_flush();
        clear_got();
        m_out_ready = 1'b1;
        m_in_valid = 1'b1; m_in_data = 16'hFFFF; tick();
        m_in_valid = 1'b0; tick();
        m_out_ready = 1'b0; m_flush = 1'b1; tick();
        m_flush = 1'b0;
        total++; if (m_fill !== 6'd6 || m_out_last !== 1'b1) begin bad++; $display("FAIL rstmid setup fill/last got=%0d/%0b exp=6/1", m_fill, m_out_last); end
        rst = 1'b1; tick();
        rst = 1'b0;
        total++; if (m_out_valid !== 1'b0 || m_out_last !== 1'b0) begin bad++; $display("FAIL rstmid valid/last got=%0b/%0b exp=0/0", m_out_valid, m_out_last); end
        total++; if (m_fill !== 6'd0 || m_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid fill/in_ready got=%0d/%0b exp=0/1", m_fill, m_in_ready); end
        clear_got();
        m_out_ready = 1'b1;
        repeat (4) tick();
        total++; if (got_d.size() != 0) begin bad++; $display("FAIL rstmid residual words got=%0d exp=0", got_d.size()); end
    endtask

    task automatic test_flush_edges();
        clear_got();
        m_flush = 1'b1; tick();
        m_flush = 1'b0;
        total++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1 || m_fill !== 6'd0) begin
            bad++; $display("FAIL flush_empty valid/in_ready/fill got=%0b/%0b/%0d exp=0/1/0", m_out_valid, m_in_ready, m_fill);
        end
        m_flush = 1'b1; m_in_valid = 1'b1; m_in_data = 16'h0001; tick();
        m_flush = 1'b0; m_in_valid = 1'b0;
        repeat (3) tick();
        total++;
        if (got_d.size() != 2) begin bad++; $display("FAIL flush_push word_count got=%0d exp=2", got_d.size()); end
        else if (got_d[0] !== 10'h001 || got_l[0] !== 1'b0 || got_d[1] !== 10'h000 || got_l[1] !== 1'b1) begin
            bad++; $display("FAIL flush_push words got=%h/%0b,%h/%0b exp=001/0,000/1", got_d[0], got_l[0], got_d[1], got_l[1]);
        end
        total++; if (m_fill !== 6'd0 || m_in_ready !== 1'b1) begin bad++; $display("FAIL flush_push end fill/in_ready got=%0d/%0b exp=0/1", m_fill, m_in_ready); end
    endtask

    // Random traffic against a model that keeps the pending stream as a bit queue
    task automatic test_random();
        bit q[$];
        bit mfp = 1'b0;
        bit eov, eir, elast, do_pop, do_push;
        logic [OUT_W-1:0] ed;
        int sz, n;
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            sz    = q.size();
            eir   = !mfp && (sz <= ACC_W - IN_W);
            eov   = (sz >= OUT_W) || (mfp && sz > 0);
            elast = eov && mfp && (sz <= OUT_W);
            ed    = '0;
            for (int i = 0; i < OUT_W && i < sz; i++) ed[i] = q[i];
            total++; if (m_out_valid !== eov) begin bad++; $display("FAIL rand c%0d out_valid got=%0b exp=%0b", c, m_out_valid, eov); end
            total++; if (m_in_ready !== eir) begin bad++; $display("FAIL rand c%0d in_ready got=%0b exp=%0b", c, m_in_ready, eir); end
            total++; if (m_out_last !== elast) begin bad++; $display("FAIL rand c%0d out_last got=%0b exp=%0b", c, m_out_last, elast); end
            total++; if (m_fill !== CNT_W'(sz)) begin bad++; $display("FAIL rand c%0d fill_bits got=%0d exp=%0d", c, m_fill, sz); end
            if (eov) begin
                total++; if (m_out_data !== ed) begin bad++; $display("FAIL rand c%0d out_data got=%h exp=%h", c, m_out_data, ed); end
            end
            m_in_valid  = ($urandom_range(0, 3) != 0);
            m_in_data   = 16'($urandom);
            m_out_ready = ($urandom_range(0, 3) != 0);
            m_flush     = ($urandom_range(0, 19) == 0);
            do_pop  = eov && m_out_ready;
            do_push = m_in_valid && eir;
            n = do_pop ? ((sz < OUT_W) ? sz : OUT_W) : 0;
            repeat (n) void'(q.pop_front());
            if (do_push) for (int i = 0; i < IN_W; i++) q.push_back(m_in_data[i]);
            if (do_pop && elast) mfp = 1'b0;
            else if (m_flush && !mfp && q.size() > 0) mfp = 1'b1;
            tick();
        end
        m_in_valid = 1'b0; m_flush = 1'b0; m_out_ready = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic_flush();
        test_stream();
        test_back_pressure();
        test_bit_order();
        test_reset_mid_flush();
        test_flush_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
